ppu_bg_shifter: RTL and testbench
=================================

# ppu_bg_shifter

Background pixel pipeline of the PPU, directly downstream of the background rendering FSM. Each fetch phase of that FSM (`NT`, `AT`, `BG_Lsb`, `BG_Msb`) returns one VRAM byte; this block captures those bytes into tile latches, reloads 16-bit shift registers at tile boundaries, and shifts them once per NES dot. It emits one registered 4-bit background palette index per visible dot to the pixel mux/palette stage, applying fine-X scroll, background enable and left-column clipping.

## Interface
- (no parameters)
- clk  in  1  PPU clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- fetch_state  in  3  current FSM state: 000 SLEEP, 001 IDLE, 010 NT, 011 AT, 100 BG_Lsb, 101 BG_Msb, 110 VBLANK
- data_valid  in  1  vram_data is valid for the phase given by fetch_state
- vram_data  in  8  VRAM read data
- at_quad  in  2  attribute quadrant select ({coarse_y[1], coarse_x[1]})
- reload  in  1  tile boundary: transfer latches into shift-register low bytes
- pix_en  in  1  one-cycle strobe per NES dot
- line_start  in  1  first dot of a scanline; clears the column counter
- fine_x  in  3  fine horizontal scroll
- bg_en  in  1  background rendering enable (PPUMASK bit 3)
- bg_left_en  in  1  show background in columns 0–7 (PPUMASK bit 1)
- nt_tile  out  8  latched nametable byte, used by pattern address generation
- pix_out  out  4  {attr_hi, attr_lo, pat_hi, pat_lo}
- pix_opaque  out  1  pattern bits != 00 after masking
- pix_valid  out  1  pix_out is valid this cycle

## Operation
- Latches, updated only when data_valid=1:
  - NT: nt_tile <= vram_data
  - AT: at_bits <= vram_data[2*at_quad+1 : 2*at_quad]
  - BG_Lsb: pt_lo <= vram_data
  - BG_Msb: pt_hi <= vram_data
  - Any other state: data ignored, no latch changes.
- Four 16-bit shifters: sh_plo, sh_phi, sh_alo, sh_ahi.
  - pix_en only: shift left by one, LSB filled with 0.
  - reload only: low byte <= pt_lo, pt_hi, {8{at_bits[0]}}, {8{at_bits[1]}} respectively; high byte unchanged.
  - Both in the same cycle: sh <= {sh[14:7], latch}.
- Pixel selection uses shifter bit (15 − fine_x), sampled before the shift in that cycle.
- Column counter col, 9 bits:
  - line_start=1: col <= pix_en ? 1 : 0. Any pixel produced in that cycle uses column 0.
  - Otherwise col increments on pix_en and saturates at 511.
- Masking, applied in this order; masked pixels force pix_out=0 and pix_opaque=0:
  - bg_en=0
  - clip active (see Configuration)
  - pattern bits 00: pix_out=0 and pix_opaque=0, including the attribute bits.
- pix_valid is asserted only for dots with col<256.
- Reset: all latches, shifters, col, nt_tile, pix_out, pix_opaque and pix_valid are 0. Reset applies mid-line and overrides every other input.

## Timing
- Latch update: 1 cycle after data_valid.
- Shifter update: 1 cycle after pix_en or reload.
- Output latency: pix_out, pix_opaque and pix_valid are registered. They are valid exactly 1 cycle after the pix_en that produced them.
  - pix_valid is a single-cycle pulse.
  - pix_out and pix_opaque hold their values until the next valid pixel.
- A pixel is emitted only when pix_en=1. There are no back-to-back constraints: pix_en may be asserted every cycle.
- fine_x, bg_en and bg_left_en are sampled in the pix_en cycle. No internal resynchronisation.
- data_valid together with reload in the same cycle: the shifter loads the old latch value, and the latch updates in parallel.

## Configuration
- Macro: `PPU_BG_LEFT_CLIP_EN`
  - Defined: a pixel is clipped when col<8 and bg_left_en=0.
  - Undefined: clipping logic is not compiled, bg_left_en is ignored, and columns 0–7 render normally.

## Test plan
- Fetch sequence NT=0x24, AT=0xE4 with at_quad=2, Lsb=0xF0, Msb=0x0F, then reload -> nt_tile=0x24, at_bits=10, sh_plo[7:0]=0xF0, sh_phi[7:0]=0x0F, sh_ahi[7:0]=0xFF, sh_alo[7:0]=0x00.
- Perform 8 pix_en, then a second reload with the same tile, fine_x=0, then 8 more pix_en -> pix_out = 0x9 ×4 followed by 0xA ×4, one cycle after each strobe, with pix_opaque=1.
- Same tile with fine_x=3 -> the first emitted pixel equals the 4th pixel of the fine_x=0 case.
- Pattern bytes 0x00/0x00 with at_bits=11 -> pix_out=0x0, pix_opaque=0, pix_valid=1.
- With `PPU_BG_LEFT_CLIP_EN` defined and bg_left_en=0, line_start then 10 pix_en on an opaque tile -> 8 zero pixels, then opaque pixels at columns 8–9. Without the macro -> all 10 pixels opaque.
- Assert rst mid-line after 5 pixels -> all outputs 0 the next cycle, and col restarts at 0. Also: 300 pix_en after line_start -> pix_valid stops after the 256th pixel.

Source files
------------

// File: rtl/ppu_bg_shifter.sv
// Background pixel pipeline: latches tile fetch bytes, shifts per NES dot, emits a masked 4-bit palette index.
// Optional left-column clipping is compiled in with `PPU_BG_LEFT_CLIP_EN.
module ppu_bg_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] fetch_state,
  input  logic       data_valid,
  input  logic [7:0] vram_data,
  input  logic [1:0] at_quad,
  input  logic       reload,
  input  logic       pix_en,
  input  logic       line_start,
  input  logic [2:0] fine_x,
  input  logic       bg_en,
  input  logic       bg_left_en,
  output logic [7:0] nt_tile,
  output logic [3:0] pix_out,
  output logic       pix_opaque,
  output logic       pix_valid
);

  localparam logic [2:0] ST_NT  = 3'b010;
  localparam logic [2:0] ST_AT  = 3'b011;
  localparam logic [2:0] ST_LSB = 3'b100;
  localparam logic [2:0] ST_MSB = 3'b101;

  logic [1:0]  at_bits;
  logic [7:0]  pt_lo;
  logic [7:0]  pt_hi;
  logic [1:0]  at_sel;
  logic [15:0] sh_plo, sh_phi, sh_alo, sh_ahi;
  logic [8:0]  col;
  logic [8:0]  col_p0;
  logic [3:0]  tap_p0;
  logic [3:0]  raw_p0;
  logic        clip_p0;
  logic [4:0]  pix_p0;

  // Both strobes together: shift the high byte and drop the fresh tile in below it.
  function automatic logic [15:0] shift_next(input logic [15:0] sh, input logic [7:0] ld,
                                             input logic pe, input logic rl);
    logic [15:0] r;
    case ({pe, rl})
      2'b10:   r = {sh[14:0], 1'b0};
      2'b01:   r = {sh[15:8], ld};
      2'b11:   r = {sh[14:7], ld};
      default: r = sh;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] mask_pix(input logic [3:0] raw, input logic en, input logic clip);
    logic [4:0] r;
    if (!en || clip || raw[1:0] == 2'b00) r = 5'd0;
    else                                  r = {1'b1, raw};
    return r;
  endfunction

  always_comb begin
    case (at_quad)
      2'd0:    at_sel = vram_data[1:0];
      2'd1:    at_sel = vram_data[3:2];
      2'd2:    at_sel = vram_data[5:4];
      default: at_sel = vram_data[7:6];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nt_tile <= 8'd0;
      at_bits <= 2'd0;
      pt_lo   <= 8'd0;
      pt_hi   <= 8'd0;
    end else if (data_valid) begin
      case (fetch_state)
        ST_NT:   nt_tile <= vram_data;
        ST_AT:   at_bits <= at_sel;
        ST_LSB:  pt_lo   <= vram_data;
        ST_MSB:  pt_hi   <= vram_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_plo <= 16'd0;
      sh_phi <= 16'd0;
      sh_alo <= 16'd0;
      sh_ahi <= 16'd0;
    end else begin
      sh_plo <= shift_next(sh_plo, pt_lo, pix_en, reload);
      sh_phi <= shift_next(sh_phi, pt_hi, pix_en, reload);
      sh_alo <= shift_next(sh_alo, {8{at_bits[0]}}, pix_en, reload);
      sh_ahi <= shift_next(sh_ahi, {8{at_bits[1]}}, pix_en, reload);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        col <= 9'd0;
    else if (line_start)            col <= {8'd0, pix_en};
    else if (pix_en && col != 9'd511) col <= col + 9'd1;
  end

  // p0: tap the shifters (pre-shift) and apply masking for the current dot.
  always_comb begin
    col_p0 = line_start ? 9'd0 : col;
    tap_p0 = 4'd15 - {1'b0, fine_x};
    raw_p0 = {sh_ahi[tap_p0], sh_alo[tap_p0], sh_phi[tap_p0], sh_plo[tap_p0]};
  end

`ifdef PPU_BG_LEFT_CLIP_EN
  assign clip_p0 = (col_p0 < 9'd8) && !bg_left_en;
`else
  logic unused_bg_left_en;
  assign unused_bg_left_en = bg_left_en;
  assign clip_p0 = 1'b0;
`endif

  assign pix_p0 = mask_pix(raw_p0, bg_en, clip_p0);

  // p1: registered pixel outputs; value holds between visible dots.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out    <= 4'd0;
      pix_opaque <= 1'b0;
      pix_valid  <= 1'b0;
    end else begin
      pix_valid <= pix_en && !col_p0[8];
      if (pix_en && !col_p0[8]) begin
        pix_out    <= pix_p0[3:0];
        pix_opaque <= pix_p0[4];
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_shifter.sv
// Directed self-checking bench for ppu_bg_shifter: vector table plus multi-cycle corner sequences.
module tb_ppu_bg_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fetch_state;
  logic       data_valid;
  logic [7:0] vram_data;
  logic [1:0] at_quad;
  logic       reload;
  logic       pix_en;
  logic       line_start;
  logic [2:0] fine_x;
  logic       bg_en;
  logic       bg_left_en;
  logic [7:0] nt_tile;
  logic [3:0] pix_out;
  logic       pix_opaque;
  logic       pix_valid;

  ppu_bg_shifter dut (
    .clk(clk), .rst(rst), .fetch_state(fetch_state), .data_valid(data_valid),
    .vram_data(vram_data), .at_quad(at_quad), .reload(reload), .pix_en(pix_en),
    .line_start(line_start), .fine_x(fine_x), .bg_en(bg_en), .bg_left_en(bg_left_en),
    .nt_tile(nt_tile), .pix_out(pix_out), .pix_opaque(pix_opaque), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] S_IDLE = 3'd1, S_NT = 3'd2, S_AT = 3'd3, S_LSB = 3'd4, S_MSB = 3'd5;

  typedef struct {
    logic [2:0] fs;
    logic       dv;
    logic [7:0] data;
    logic [1:0] quad;
    logic       rl;
    logic       pe;
    logic       be;
    logic [7:0] e_nt;
    logic [3:0] e_pix;
    logic       e_op;
    logic       e_vld;
  } vec_t;

  vec_t tbl [27];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [2:0] fs, input logic dv, input logic [7:0] data,
                              input logic [1:0] quad, input logic rl, input logic pe, input logic be,
                              input logic [7:0] e_nt, input logic [3:0] e_pix, input logic e_op,
                              input logic e_vld);
    vec_t v;
    v.fs = fs; v.dv = dv; v.data = data; v.quad = quad; v.rl = rl; v.pe = pe; v.be = be;
    v.e_nt = e_nt; v.e_pix = e_pix; v.e_op = e_op; v.e_vld = e_vld;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_state = S_IDLE; data_valid = 1'b0; vram_data = 8'd0; at_quad = 2'd0;
    reload = 1'b0; pix_en = 1'b0; line_start = 1'b0; fine_x = 3'd0;
  endtask

  task automatic fetch(input logic [2:0] fs, input logic [7:0] d, input logic [1:0] q);
    fetch_state = fs; data_valid = 1'b1; vram_data = d; at_quad = q;
    cycle();
    clear_inputs();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    cycle();
    reload = 1'b0;
  endtask

  task automatic run_pix(input int n);
    for (int k = 0; k < n; k++) begin
      pix_en = 1'b1;
      cycle();
    end
    pix_en = 1'b0;
  endtask

  task automatic pix_chk(input logic [3:0] ep, input logic eo, input string nm);
    pix_en = 1'b1;
    cycle();
    pix_en = 1'b0;
    line_start = 1'b0;
    check({nm, ".pix"}, pix_out, ep);
    check({nm, ".opq"}, pix_opaque, eo);
    check({nm, ".vld"}, pix_valid, 1'b1);
  endtask

  task automatic load_tile(input logic [7:0] at, input logic [1:0] q, input logic [7:0] lo,
                           input logic [7:0] hi);
    fetch(S_AT, at, q);
    fetch(S_LSB, lo, 2'd0);
    fetch(S_MSB, hi, 2'd0);
  endtask

  int vcnt;
  logic [3:0] exp_seq [8];
  logic [3:0] clip_exp;

  initial begin
    tbl[0]  = mk(S_NT,   1, 8'h24, 0, 0, 0, 1, 8'h24, 4'h0, 0, 0);
    tbl[1]  = mk(S_AT,   1, 8'hE4, 2, 0, 0, 1, 8'h24, 4'h0, 0, 0);
    tbl[2]  = mk(S_LSB,  1, 8'hF0, 0, 0, 0, 1, 8'h24, 4'h0, 0, 0);
    tbl[3]  = mk(S_MSB,  1, 8'h0F, 0, 0, 0, 1, 8'h24, 4'h0, 0, 0);
    tbl[4]  = mk(S_IDLE, 0, 8'h00, 0, 1, 0, 1, 8'h24, 4'h0, 0, 0);
    for (int i = 5; i < 13; i++) tbl[i] = mk(S_IDLE, 0, 8'h00, 0, 0, 1, 1, 8'h24, 4'h0, 0, 1);
    tbl[13] = mk(S_IDLE, 0, 8'h00, 0, 1, 0, 1, 8'h24, 4'h0, 0, 0);
    for (int i = 14; i < 18; i++) tbl[i] = mk(S_IDLE, 0, 8'h00, 0, 0, 1, 1, 8'h24, 4'h9, 1, 1);
    for (int i = 18; i < 22; i++) tbl[i] = mk(S_IDLE, 0, 8'h00, 0, 0, 1, 1, 8'h24, 4'hA, 1, 1);
    tbl[22] = mk(S_IDLE, 0, 8'h00, 0, 0, 1, 0, 8'h24, 4'h0, 0, 1);
    tbl[23] = mk(S_IDLE, 0, 8'h00, 0, 0, 1, 1, 8'h24, 4'h9, 1, 1);
    tbl[24] = mk(S_IDLE, 0, 8'h00, 0, 0, 0, 1, 8'h24, 4'h9, 1, 0);
    tbl[25] = mk(S_IDLE, 1, 8'hAA, 0, 0, 0, 1, 8'h24, 4'h9, 1, 0);
    tbl[26] = mk(S_NT,   0, 8'h55, 0, 0, 0, 1, 8'h24, 4'h9, 1, 0);

    exp_seq[0] = 4'h9; exp_seq[1] = 4'h9; exp_seq[2] = 4'h9; exp_seq[3] = 4'h9;
    exp_seq[4] = 4'hA; exp_seq[5] = 4'hA; exp_seq[6] = 4'hA; exp_seq[7] = 4'hA;

    clear_inputs();
    bg_en = 1'b1; bg_left_en = 1'b1;
    rst = 1'b1;
    cycle(); cycle();
    check("rst.nt", nt_tile, 8'h00);
    check("rst.pix", pix_out, 4'h0);
    check("rst.opq", pix_opaque, 1'b0);
    check("rst.vld", pix_valid, 1'b0);
    rst = 1'b0;
    line_start = 1'b1;
    cycle();
    line_start = 1'b0;

    for (int i = 0; i < 27; i++) begin
      fetch_state = tbl[i].fs; data_valid = tbl[i].dv; vram_data = tbl[i].data;
      at_quad = tbl[i].quad; reload = tbl[i].rl; pix_en = tbl[i].pe; bg_en = tbl[i].be;
      cycle();
      check($sformatf("vec%0d.nt", i), nt_tile, tbl[i].e_nt);
      check($sformatf("vec%0d.pix", i), pix_out, tbl[i].e_pix);
      check($sformatf("vec%0d.opq", i), pix_opaque, tbl[i].e_op);
      check($sformatf("vec%0d.vld", i), pix_valid, tbl[i].e_vld);
      clear_inputs();
      bg_en = 1'b1;
    end

    // fine_x=3 starts the tile at its 4th pixel
    load_tile(8'hE4, 2'd2, 8'hF0, 8'h0F);
    do_reload();
    run_pix(8);
    do_reload();
    fine_x = 3'd3;
    pix_chk(4'h9, 1'b1, "fx3.0");
    fine_x = 3'd3; pix_chk(4'hA, 1'b1, "fx3.1");
    fine_x = 3'd3; pix_chk(4'hA, 1'b1, "fx3.2");
    fine_x = 3'd3; pix_chk(4'hA, 1'b1, "fx3.3");
    fine_x = 3'd3; pix_chk(4'hA, 1'b1, "fx3.4");
    fine_x = 3'd0;

    // reload + pix_en + data_valid together: shifter takes the old latch
    load_tile(8'hE4, 2'd2, 8'hF0, 8'h0F);
    do_reload();
    run_pix(7);
    pix_en = 1'b1; reload = 1'b1; fetch_state = S_LSB; data_valid = 1'b1; vram_data = 8'h0F;
    cycle();
    clear_inputs();
    for (int k = 0; k < 16; k++) pix_chk(exp_seq[k % 8], 1'b1, $sformatf("both.%0d", k));

    // transparent pattern masks attribute bits too
    load_tile(8'hFF, 2'd0, 8'h00, 8'h00);
    do_reload();
    run_pix(8);
    pix_chk(4'h0, 1'b0, "transp");

    // left-column clipping from line_start coinciding with the first dot
    load_tile(8'h00, 2'd0, 8'hFF, 8'h00);
    do_reload();
    run_pix(8);
    do_reload();
    bg_left_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifdef PPU_BG_LEFT_CLIP_EN
      clip_exp = (k < 8) ? 4'h0 : 4'h1;
`else
      clip_exp = 4'h1;
`endif
      line_start = (k == 0);
      pix_chk(clip_exp, clip_exp != 4'h0, $sformatf("clip.%0d", k));
    end
    bg_left_en = 1'b1;

    // reset mid-line, then column must restart at 0
    line_start = 1'b1;
    run_pix(5);
    line_start = 1'b0;
    rst = 1'b1;
    cycle();
    check("mrst.nt", nt_tile, 8'h00);
    check("mrst.pix", pix_out, 4'h0);
    check("mrst.opq", pix_opaque, 1'b0);
    check("mrst.vld", pix_valid, 1'b0);
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 300; k++) begin
      pix_en = 1'b1;
      cycle();
      if (pix_valid) vcnt++;
      if (k == 255) check("mrst.vld255", pix_valid, 1'b1);
      if (k == 256) check("mrst.vld256", pix_valid, 1'b0);
    end
    pix_en = 1'b0;
    check("mrst.count", vcnt, 256);

    vcnt = 0;
    for (int k = 0; k < 300; k++) begin
      pix_en = 1'b1;
      line_start = (k == 0);
      cycle();
      if (pix_valid) vcnt++;
    end
    clear_inputs();
    cycle();
    check("line.count", vcnt, 256);
    check("line.after", pix_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
